// File: rtl/serdes_64b66b_pkg.sv
// ---------------------------------------------------------------------------
// serdes_64b66b_pkg
// Shared definitions for the 64B/66B receive path:
//   - sync header values that mark a block boundary as good
//   - encodings of the block-lock state machine (also exported as a debug port)
//   - tap positions of the 1 + x^39 + x^58 self-synchronous scrambler
// ---------------------------------------------------------------------------
package serdes_64b66b_pkg;

    localparam logic [1:0] C_DATA_HEADER  = 2'b01;
    localparam logic [1:0] C_COMMA_HEADER = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_TEST      = 3'd1,
        ST_SLIP      = 3'd2,
        ST_SLIP_WAIT = 3'd3,
        ST_LOCK      = 3'd4
    } lock_state_t;

    localparam int C_TAP_A = 39;
    localparam int C_TAP_B = 58;

    // Only 01 and 10 mark a block boundary; 00 and 11 mean we are misaligned.
    function automatic logic is_good_header(input logic [1:0] hdr);
        return (hdr == C_DATA_HEADER) || (hdr == C_COMMA_HEADER);
    endfunction

endpackage

// File: rtl/serdes_64b66b_descrambler.sv
// ---------------------------------------------------------------------------
// serdes_64b66b_descrambler
// Self-synchronous descrambler for polynomial 1 + x^39 + x^58, bit 0 first.
// The output is combinational; the caller registers it. History of the last
// 58 received (still scrambled) bits is carried across blocks.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (clears the history)
//   i_valid  history advances only on valid blocks
//   i_data   64-bit scrambled block
//   o_data   64-bit descrambled block (combinational)
// ---------------------------------------------------------------------------
module serdes_64b66b_descrambler
    import serdes_64b66b_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    // r_hist[57] is the most recently received bit (bit 63 of the last block).
    logic [C_TAP_B-1:0]    r_hist;
    logic [C_TAP_B+63:0]   w_ext;

    // Concatenating history below the new block turns the cross-block taps
    // into plain fixed offsets: stream bit i of this block sits at w_ext[58+i].
    always_comb begin
        w_ext  = {i_data, r_hist};
        o_data = '0;
        for (int i = 0; i < 64; i++) begin
            o_data[i] = w_ext[C_TAP_B + i] ^ w_ext[C_TAP_B + i - C_TAP_A] ^ w_ext[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
        end else if (i_valid) begin
            r_hist <= i_data[63:64-C_TAP_B];
        end
    end

endmodule

// File: rtl/serdes_64b66b_rx_block_sync.sv
// ---------------------------------------------------------------------------
// serdes_64b66b_rx_block_sync
// Sits between the RX gearbox and the 64B/66B decoder. Qualifies sync
// headers, runs the block-lock state machine, requests gearbox slips until
// lock is found, and forwards the block to the decoder with 1 clock latency.
//
// Optional feature macro: SERDES_64B66B_RX_DESCRAMBLE_EN
//   defined   -> O_rx_data carries the descrambled payload
//   undefined -> payload is forwarded unmodified
//
// Ports:
//   I_pcs_rx_clk       RX user clock
//   I_pcs_rx_rst_n     asynchronous active-low reset
//   I_rx_data/valid    block payload from gearbox
//   I_rx_header/valid  sync header from gearbox
//   O_rx_slip          one-cycle slip request to gearbox
//   O_rx_data/valid    registered payload to decoder
//   O_rx_header/valid  registered header to decoder
//   O_rx_block_sync    block lock achieved
//   O_rx_slip_cnt      saturating count of slips issued
//   O_rx_lock_state    current lock FSM state (debug)
// ---------------------------------------------------------------------------
module serdes_64b66b_rx_block_sync
    import serdes_64b66b_pkg::*;
#(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT_CYC  = 32
) (
    input  logic        I_pcs_rx_clk,
    input  logic        I_pcs_rx_rst_n,
    input  logic [63:0] I_rx_data,
    input  logic        I_rx_valid,
    input  logic [1:0]  I_rx_header,
    input  logic        I_rx_header_valid,
    output logic        O_rx_slip,
    output logic [63:0] O_rx_data,
    output logic        O_rx_valid,
    output logic [1:0]  O_rx_header,
    output logic        O_rx_header_valid,
    output logic        O_rx_block_sync,
    output logic [7:0]  O_rx_slip_cnt,
    output logic [2:0]  O_rx_lock_state
);

    localparam logic [6:0] L_SH_LAST   = 7'(SH_CNT_MAX - 1);
    localparam logic [4:0] L_INV_MAX   = 5'(SH_INVALID_MAX);
    localparam logic [5:0] L_WAIT_LAST = 6'(SLIP_WAIT_CYC - 1);

    lock_state_t r_state;
    logic [6:0]  r_shCnt;
    logic [4:0]  r_invCnt;
    logic [5:0]  r_waitCnt;
    logic        r_slip;
    logic [7:0]  r_slipCnt;
    logic        r_blockSync;

    logic [63:0] r_data;
    logic        r_valid;
    logic [1:0]  r_header;
    logic        r_headerValid;

    logic        w_hdrEvent;
    logic        w_hdrGood;
    logic [4:0]  w_invNext;
    logic [7:0]  w_slipCntNext;
    logic [63:0] w_dataIn;

    assign w_hdrEvent    = I_rx_header_valid & I_rx_valid;
    assign w_hdrGood     = is_good_header(I_rx_header);
    assign w_invNext     = r_invCnt + {4'd0, ~w_hdrGood};
    assign w_slipCntNext = (r_slipCnt == 8'hFF) ? r_slipCnt : r_slipCnt + 8'd1;

`ifdef SERDES_64B66B_RX_DESCRAMBLE_EN
    serdes_64b66b_descrambler u_descrambler (
        .i_clk   (I_pcs_rx_clk),
        .i_rst_n (I_pcs_rx_rst_n),
        .i_valid (I_rx_valid),
        .i_data  (I_rx_data),
        .o_data  (w_dataIn)
    );
`else
    assign w_dataIn = I_rx_data;
`endif

    // Data path: plain one-stage pipeline, independent of lock state.
    always_ff @(posedge I_pcs_rx_clk or negedge I_pcs_rx_rst_n) begin
        if (!I_pcs_rx_rst_n) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_header      <= '0;
            r_headerValid <= 1'b0;
        end else begin
            r_data        <= w_dataIn;
            r_valid       <= I_rx_valid;
            r_header      <= I_rx_header;
            r_headerValid <= I_rx_header_valid;
        end
    end

    // Block-lock FSM. The slip pulse and block_sync are set on the same edge
    // that enters SLIP, so a lost lock and its slip request line up.
    always_ff @(posedge I_pcs_rx_clk or negedge I_pcs_rx_rst_n) begin
        if (!I_pcs_rx_rst_n) begin
            r_state     <= ST_INIT;
            r_shCnt     <= '0;
            r_invCnt    <= '0;
            r_waitCnt   <= '0;
            r_slip      <= 1'b0;
            r_slipCnt   <= '0;
            r_blockSync <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_shCnt     <= '0;
                    r_invCnt    <= '0;
                    r_waitCnt   <= '0;
                    r_blockSync <= 1'b0;
                    r_state     <= ST_TEST;
                end
                ST_TEST: begin
                    if (w_hdrEvent) begin
                        if (!w_hdrGood) begin
                            r_state   <= ST_SLIP;
                            r_slip    <= 1'b1;
                            r_slipCnt <= w_slipCntNext;
                            r_shCnt   <= '0;
                        end else if (r_shCnt == L_SH_LAST) begin
                            r_state     <= ST_LOCK;
                            r_blockSync <= 1'b1;
                            r_shCnt     <= '0;
                            r_invCnt    <= '0;
                        end else begin
                            r_shCnt <= r_shCnt + 7'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_hdrEvent) begin
                        // Too many bad headers takes priority over window end.
                        if (w_invNext == L_INV_MAX) begin
                            r_state     <= ST_SLIP;
                            r_blockSync <= 1'b0;
                            r_slip      <= 1'b1;
                            r_slipCnt   <= w_slipCntNext;
                            r_shCnt     <= '0;
                            r_invCnt    <= '0;
                        end else if (r_shCnt == L_SH_LAST) begin
                            r_shCnt  <= '0;
                            r_invCnt <= '0;
                        end else begin
                            r_shCnt  <= r_shCnt + 7'd1;
                            r_invCnt <= w_invNext;
                        end
                    end
                end
                ST_SLIP: begin
                    r_waitCnt <= '0;
                    r_state   <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    // Gearbox is realigning; headers here are meaningless.
                    if (r_waitCnt == L_WAIT_LAST) begin
                        r_state   <= ST_TEST;
                        r_shCnt   <= '0;
                        r_invCnt  <= '0;
                        r_waitCnt <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 6'd1;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_blockSync <= 1'b0;
                end
            endcase
        end
    end

    assign O_rx_slip         = r_slip;
    assign O_rx_data         = r_data;
    assign O_rx_valid        = r_valid;
    assign O_rx_header       = r_header;
    assign O_rx_header_valid = r_headerValid;
    assign O_rx_block_sync   = r_blockSync;
    assign O_rx_slip_cnt     = r_slipCnt;
    assign O_rx_lock_state   = r_state;

endmodule

// File: tb/tb_serdes_64b66b_rx_block_sync.sv
// ---------------------------------------------------------------------------
// tb_serdes_64b66b_rx_block_sync
// Directed bench for the 64B/66B RX block-lock stage: lock acquisition,
// slip on a bad header during test, window behaviour while locked, slip
// counter saturation, asynchronous reset mid-lock, and (when
// SERDES_64B66B_RX_DESCRAMBLE_EN is defined) descrambling of a scrambled
// all-zero stream.
// ---------------------------------------------------------------------------
module tb_serdes_64b66b_rx_block_sync;

    logic        clk;
    logic        rstN;
    logic [63:0] rxData;
    logic        rxValid;
    logic [1:0]  rxHeader;
    logic        rxHeaderValid;
    logic        oSlip;
    logic [63:0] oData;
    logic        oValid;
    logic [1:0]  oHeader;
    logic        oHeaderValid;
    logic        oBlockSync;
    logic [7:0]  oSlipCnt;
    logic [2:0]  oLockState;

    int vectors;
    int miscompares;

    serdes_64b66b_rx_block_sync dut (
        .I_pcs_rx_clk      (clk),
        .I_pcs_rx_rst_n    (rstN),
        .I_rx_data         (rxData),
        .I_rx_valid        (rxValid),
        .I_rx_header       (rxHeader),
        .I_rx_header_valid (rxHeaderValid),
        .O_rx_slip         (oSlip),
        .O_rx_data         (oData),
        .O_rx_valid        (oValid),
        .O_rx_header       (oHeader),
        .O_rx_header_valid (oHeaderValid),
        .O_rx_block_sync   (oBlockSync),
        .O_rx_slip_cnt     (oSlipCnt),
        .O_rx_lock_state   (oLockState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report a miscompare on one line.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, settle 1 time unit.
    task automatic applyStimulus(input logic [1:0] hdr, input logic hv,
                                 input logic v, input logic [63:0] data);
        rxHeader      = hdr;
        rxHeaderValid = hv;
        rxValid       = v;
        rxData        = data;
        @(posedge clk);
        #1;
    endtask

    // Reset, release on a falling edge, then one idle clock (INIT -> TEST).
    task automatic doReset();
        rstN          = 1'b0;
        rxHeader      = 2'b00;
        rxHeaderValid = 1'b0;
        rxValid       = 1'b0;
        rxData        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 64'd0);
    endtask

    // 64 alternating good headers from TEST; lock follows the last one.
    task automatic acquireLock();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(i[0] ? 2'b10 : 2'b01, 1'b1, 1'b1, 64'h1000 + 64'(i));
        end
    endtask

    logic        sawSlip;
    logic        sawLock;
    logic [57:0] scrHist;
    logic [121:0] scrExt;
    logic [63:0] scrBlk;

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset state with busy inputs.
        rstN          = 1'b0;
        rxHeader      = 2'b11;
        rxHeaderValid = 1'b1;
        rxValid       = 1'b1;
        rxData        = 64'hDEAD_BEEF_0123_4567;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_slip",      64'(oSlip),        64'd0);
        checkOutput("rst_data",      oData,             64'd0);
        checkOutput("rst_valid",     64'(oValid),       64'd0);
        checkOutput("rst_header",    64'(oHeader),      64'd0);
        checkOutput("rst_hdr_valid", 64'(oHeaderValid), 64'd0);
        checkOutput("rst_sync",      64'(oBlockSync),   64'd0);
        checkOutput("rst_slip_cnt",  64'(oSlipCnt),     64'd0);
        checkOutput("rst_state",     64'(oLockState),   64'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 64'd0);
        checkOutput("init_to_test", 64'(oLockState), 64'd1);

        // Lock acquisition from 64 alternating good headers.
        sawSlip = 1'b0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(i[0] ? 2'b10 : 2'b01, 1'b1, 1'b1, 64'hA5A5_0000_0000_0000 + 64'(i));
            if (oSlip) sawSlip = 1'b1;
            if (i == 5) begin
                checkOutput("pass_header", 64'(oHeader), 64'd2);
                checkOutput("pass_valid", 64'({oValid, oHeaderValid}), 64'd3);
`ifndef SERDES_64B66B_RX_DESCRAMBLE_EN
                checkOutput("pass_data", oData, 64'hA5A5_0000_0000_0005);
`endif
            end
            if (i == 62) checkOutput("sync_before_64", 64'(oBlockSync), 64'd0);
            if (i == 63) begin
                checkOutput("sync_after_64", 64'(oBlockSync), 64'd1);
                checkOutput("state_lock", 64'(oLockState), 64'd4);
            end
        end
        checkOutput("no_slip_lock", 64'(sawSlip), 64'd0);
        applyStimulus(2'b01, 1'b0, 1'b1, 64'd0);
        checkOutput("hdr_valid_low", 64'(oHeaderValid), 64'd0);

        // Bad header on the 10th event during TEST.
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(2'b01, 1'b1, 1'b1, 64'd0);
        checkOutput("test_no_slip", 64'(oSlip), 64'd0);
        applyStimulus(2'b00, 1'b1, 1'b1, 64'd0);
        checkOutput("bad_slip", 64'(oSlip), 64'd1);
        checkOutput("bad_slip_cnt", 64'(oSlipCnt), 64'd1);
        checkOutput("bad_state_slip", 64'(oLockState), 64'd2);
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b1, 64'd0);
            if (k == 1) begin
                checkOutput("slip_one_cycle", 64'(oSlip), 64'd0);
                checkOutput("state_wait", 64'(oLockState), 64'd3);
            end
            if (k == 32) checkOutput("still_waiting", 64'(oLockState), 64'd3);
            if (k == 33) checkOutput("wait_to_test", 64'(oLockState), 64'd1);
        end
        for (int i = 0; i < 64; i++) begin
            applyStimulus(2'b10, 1'b1, 1'b1, 64'd0);
            if (i == 62) checkOutput("relock_early", 64'(oBlockSync), 64'd0);
        end
        checkOutput("relock", 64'(oBlockSync), 64'd1);
        checkOutput("relock_slip_cnt", 64'(oSlipCnt), 64'd1);

        // Locked window with 15 bad headers keeps lock.
        sawSlip = 1'b0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus((i < 15) ? 2'b00 : 2'b01, 1'b1, 1'b1, 64'd0);
            if (oSlip) sawSlip = 1'b1;
        end
        checkOutput("win15_sync", 64'(oBlockSync), 64'd1);
        checkOutput("win15_state", 64'(oLockState), 64'd4);
        checkOutput("win15_no_slip", 64'(sawSlip), 64'd0);
        // Next window: 10 good then 16 bad drops lock on the 16th.
        for (int i = 0; i < 10; i++) applyStimulus(2'b10, 1'b1, 1'b1, 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b11, 1'b1, 1'b1, 64'd0);
            if (i == 14) begin
                checkOutput("bad15_sync", 64'(oBlockSync), 64'd1);
                checkOutput("bad15_slip", 64'(oSlip), 64'd0);
            end
        end
        checkOutput("bad16_sync", 64'(oBlockSync), 64'd0);
        checkOutput("bad16_slip", 64'(oSlip), 64'd1);
        checkOutput("bad16_state", 64'(oLockState), 64'd2);
        checkOutput("bad16_slip_cnt", 64'(oSlipCnt), 64'd2);

        // Asynchronous reset between edges while locked.
        doReset();
        acquireLock();
        applyStimulus(2'b01, 1'b1, 1'b1, 64'h0BAD_CAFE_0000_0001);
        checkOutput("pre_rst_sync", 64'(oBlockSync), 64'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_sync", 64'(oBlockSync), 64'd0);
        checkOutput("async_data", oData, 64'd0);
        checkOutput("async_valids", 64'({oValid, oHeaderValid, oHeader}), 64'd0);
        checkOutput("async_state", 64'(oLockState), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("released_init", 64'(oLockState), 64'd0);
        applyStimulus(2'b01, 1'b1, 1'b1, 64'd0);
        checkOutput("released_test", 64'(oLockState), 64'd1);

`ifdef SERDES_64B66B_RX_DESCRAMBLE_EN
        // Scrambled all-zero payload, scrambler seeded with all ones.
        doReset();
        scrHist = 58'h3FF_FFFF_FFFF_FFFF;
        for (int b = 0; b < 5; b++) begin
            scrExt = '0;
            scrExt[57:0] = scrHist;
            for (int i = 0; i < 64; i++) scrExt[58 + i] = scrExt[19 + i] ^ scrExt[i];
            scrBlk  = scrExt[121:58];
            scrHist = scrExt[121:64];
            applyStimulus(2'b01, 1'b1, 1'b1, scrBlk);
            if (b >= 1) checkOutput("descr_zero", oData, 64'd0);
            if (b == 1) checkOutput("descr_header", 64'(oHeader), 64'd1);
        end
`endif

        // Continuous bad headers: slip counter saturates, never locks.
        doReset();
        sawLock = 1'b0;
        for (int c = 0; c < 10400; c++) begin
            applyStimulus(2'b11, 1'b1, 1'b1, 64'd0);
            if (oBlockSync) sawLock = 1'b1;
            if (c == 40) checkOutput("sat_early_cnt", 64'(oSlipCnt), 64'd2);
        end
        checkOutput("sat_slip_cnt", 64'(oSlipCnt), 64'd255);
        checkOutput("sat_no_lock", 64'(sawLock), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
